// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder used by the serial adder datapath, one bit per cycle.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one result bit per clock, LSB first, WIDTH shift cycles per add.
// Define SERIAL_ADD_OVF_EN to add a registered two's-complement overflow output (ovf).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic [WIDTH-1:0] pSum_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  logic             faSum;
  logic             faCarry;
  logic [WIDTH-1:0] pSum_d;
  logic             lastBit;

  fa_cell uFaCell (
    .x (aShift_q[0]),
    .y (bShift_q[0]),
    .ci(carry_q),
    .s (faSum),
    .co(faCarry)
  );

  // New sum bit enters at the MSB so after WIDTH shifts the LSB lands at bit 0.
  assign pSum_d  = {faSum, pSum_q[WIDTH-1:1]};
  assign lastBit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      aShift_q <= '0;
      bShift_q <= '0;
      pSum_q   <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            aShift_q <= a;
            bShift_q <= b;
            carry_q  <= cin;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          aShift_q <= aShift_q >> 1;
          bShift_q <= bShift_q >> 1;
          pSum_q   <= pSum_d;
          carry_q  <= faCarry;
          cnt_q    <= cnt_q + 1'b1;
          if (lastBit) begin
            sum_q   <= pSum_d;
            cout_q  <= faCarry;
`ifdef SERIAL_ADD_OVF_EN
            // carry_q here is the carry into the MSB position.
            ovf_q   <= carry_q ^ faCarry;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8; define SERIAL_ADD_OVF_EN to also cover ovf.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   edgeCnt  = 0;
  exp_t sbQ[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Pushes the reference result, then presents one accepted start and scrambles the operands.
  task automatic startOp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    exp_t        e;
    logic [W:0]  full;
    full   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    sbQ.push_back(e);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  // Latency is in edges after the accepting edge; seen stays 0 if the bound expires.
  task automatic waitDone(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 3 * W; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checks++; if (sum !== '0) begin failures++; $display("[TB] FAIL reset_sum got=%h want=00", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout got=%b want=0", cout); end
`ifdef SERIAL_ADD_OVF_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b want=0", ovf); end
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [W-1:0] ta[3] = '{8'h0F, 8'hFF, 8'hFF};
    logic [W-1:0] tb[3] = '{8'h01, 8'h01, 8'hFF};
    logic         tc[3] = '{1'b0, 1'b0, 1'b1};
    exp_t e;
    int   lat;
    bit   seen;
    for (int i = 0; i < 3; i++) begin
      startOp(ta[i], tb[i], tc[i]);
      waitDone(lat, seen);
      e = sbQ.pop_front();
      checks++; if (!seen) begin failures++; $display("[TB] FAIL basic_done_timeout op=%0d got=none want=pulse", i); end
      checks++; if (lat != W) begin failures++; $display("[TB] FAIL basic_latency op=%0d got=%0d want=%0d", i, lat, W); end
      checks++; if (sum !== e.sum) begin failures++; $display("[TB] FAIL basic_sum op=%0d got=%h want=%h", i, sum, e.sum); end
      checks++; if (cout !== e.cout) begin failures++; $display("[TB] FAIL basic_cout op=%0d got=%b want=%b", i, cout, e.cout); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_width op=%0d got=%b want=0", i, done); end
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int   doneCnt = 0;
    startOp(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    a = 8'hAA; b = 8'hAA; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    e = sbQ.pop_front();
    checks++; if (doneCnt != 1) begin failures++; $display("[TB] FAIL ignore_done_count got=%0d want=1", doneCnt); end
    checks++; if (sum !== e.sum) begin failures++; $display("[TB] FAIL ignore_sum got=%h want=%h", sum, e.sum); end
    checks++; if (cout !== e.cout) begin failures++; $display("[TB] FAIL ignore_cout got=%b want=%b", cout, e.cout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ignore_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_midop;
    exp_t e;
    int   lat;
    bit   seen;
    int   doneCnt = 0;
    startOp(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    sbQ.delete();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got=%b want=0", busy); end
    checks++; if (sum !== '0) begin failures++; $display("[TB] FAIL midreset_sum got=%h want=00", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL midreset_cout got=%b want=0", cout); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    checks++; if (doneCnt != 0) begin failures++; $display("[TB] FAIL midreset_no_done got=%0d want=0", doneCnt); end
    startOp(8'h01, 8'h01, 1'b0);
    waitDone(lat, seen);
    e = sbQ.pop_front();
    checks++; if (!seen) begin failures++; $display("[TB] FAIL postreset_timeout got=none want=pulse"); end
    checks++; if (sum !== e.sum) begin failures++; $display("[TB] FAIL postreset_sum got=%h want=%h", sum, e.sum); end
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf;
    logic [W-1:0] ta[3] = '{8'h7F, 8'h80, 8'h01};
    logic [W-1:0] tb[3] = '{8'h01, 8'h80, 8'h01};
    exp_t e;
    int   lat;
    bit   seen;
    for (int i = 0; i < 3; i++) begin
      startOp(ta[i], tb[i], 1'b0);
      waitDone(lat, seen);
      e = sbQ.pop_front();
      checks++; if (!seen) begin failures++; $display("[TB] FAIL ovf_timeout op=%0d got=none want=pulse", i); end
      checks++; if (sum !== e.sum) begin failures++; $display("[TB] FAIL ovf_sum op=%0d got=%h want=%h", i, sum, e.sum); end
      checks++; if (cout !== e.cout) begin failures++; $display("[TB] FAIL ovf_cout op=%0d got=%b want=%b", i, cout, e.cout); end
      checks++; if (ovf !== e.ovf) begin failures++; $display("[TB] FAIL ovf_flag op=%0d got=%b want=%b", i, ovf, e.ovf); end
    end
  endtask
`endif

  // Each start lands in the first IDLE cycle, so done pulses are W+2 edges apart.
  task automatic test_back_to_back;
    exp_t         e;
    int           lat;
    bit           seen;
    int           lastDoneEdge = -1;
    logic [W-1:0] prevSum  = sum;
    logic         prevCout = cout;
    for (int i = 0; i < 1000; i++) begin
      startOp(W'($urandom), W'($urandom), 1'($urandom));
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy op=%0d got=%b want=1", i, busy); end
      checks++; if ({prevCout, sum} !== {prevCout, prevSum} || cout !== prevCout) begin
        failures++; $display("[TB] FAIL b2b_hold op=%0d got=%b/%h want=%b/%h", i, cout, sum, prevCout, prevSum);
      end
      waitDone(lat, seen);
      e = sbQ.pop_front();
      checks++; if (!seen) begin
        failures++; $display("[TB] FAIL b2b_timeout op=%0d got=none want=pulse", i);
        break;
      end
      if (lastDoneEdge >= 0) begin
        checks++; if (edgeCnt - lastDoneEdge != W + 2) begin
          failures++; $display("[TB] FAIL b2b_spacing op=%0d got=%0d want=%0d", i, edgeCnt - lastDoneEdge, W + 2);
        end
      end
      lastDoneEdge = edgeCnt;
      checks++; if (sum !== e.sum || cout !== e.cout) begin
        failures++; $display("[TB] FAIL b2b_result op=%0d got=%b/%h want=%b/%h", i, cout, sum, e.cout, e.sum);
      end
`ifdef SERIAL_ADD_OVF_EN
      checks++; if (ovf !== e.ovf) begin failures++; $display("[TB] FAIL b2b_ovf op=%0d got=%b want=%b", i, ovf, e.ovf); end
`endif
      prevSum  = e.sum;
      prevCout = e.cout;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ignore_start;
    test_reset_midop;
`ifdef SERIAL_ADD_OVF_EN
    test_ovf;
`endif
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
